ps2_fifo_sb_ctrl: RTL and testbench

System-bus PS/2 keyboard controller, successor to the single-register PS/2 controller. It has an integrated PS/2 frame receiver, a parametrised scan-code FIFO, sticky overflow and parity-error flags, and an interrupt with a runtime enable. It sits on the system bus as a peripheral slave and drives one interrupt line to the core.

---
 rtl/ps2_fifo_sb_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_fifo_sb_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ps2_fifo_sb_ctrl.sv
// PS/2 keyboard controller on the system bus: frame receiver, scan-code FIFO, sticky flags, interrupt.
// Optional macro PS2_PARITY_CHECK_EN drops frames with bad odd parity or stop bit and raises PERR.
module ps2_fifo_sb_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  input  logic        kclk_i,
  input  logic        kdata_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [31:0] ADDR_SCAN   = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0008;
  localparam logic [31:0] ADDR_RESET  = 32'h0000_0024;

  typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_e;

  rx_state_e   state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [TW-1:0] to_q, to_d;
  logic        push_q, push_d;
  logic [7:0]  push_data_q, push_data_d;
  logic [1:0]  kclk_sync_q, kdata_sync_q;
  logic        kclk_prev_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        ovf_q, ie_q, pending_q;
  logic [31:0] read_data_q, rdata_s;
  logic        kclk_fall_s, kdata_s;
  logic        rd_s, wr_s, soft_rst_s, status_wr_s, ctrl_wr_s;
  logic        empty_s, full_s, do_pop_s, do_push_s, ovf_set_s, perr_bit_s;
  logic [7:0]  cnt8_s;
`ifdef PS2_PARITY_CHECK_EN
  logic        par_q, par_d;
  logic        perr_set_q, perr_set_d;
  logic        perr_q;
`endif

  assign kclk_fall_s = kclk_prev_q & ~kclk_sync_q[1];
  assign kdata_s     = kdata_sync_q[1];
  assign rd_s        = req_i & ~write_enable_i;
  assign wr_s        = req_i & write_enable_i;
  assign soft_rst_s  = wr_s & (addr_i == ADDR_RESET) & (write_data_i == 32'h0000_0001);
  assign status_wr_s = wr_s & (addr_i == ADDR_STATUS);
  assign ctrl_wr_s   = wr_s & (addr_i == ADDR_CTRL);

  assign empty_s   = (cnt_q == CW'(0));
  assign full_s    = (cnt_q == CW'(FIFO_DEPTH));
  assign do_pop_s  = rd_s & (addr_i == ADDR_SCAN) & ~empty_s;
  assign do_push_s = push_q & (~full_s | do_pop_s);
  assign ovf_set_s = push_q & full_s & ~do_pop_s;
  assign cnt8_s    = 8'(cnt_q);

  // Idle-high line values at reset so no spurious falling edge appears afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kclk_sync_q  <= 2'b11;
      kdata_sync_q <= 2'b11;
      kclk_prev_q  <= 1'b1;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[0], kclk_i};
      kdata_sync_q <= {kdata_sync_q[0], kdata_i};
      kclk_prev_q  <= kclk_sync_q[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RX_IDLE;
      bitcnt_q    <= 4'd0;
      shift_q     <= 8'h00;
      to_q        <= '0;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
      perr_set_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      to_q        <= to_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
      perr_set_q  <= perr_set_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    to_d        = to_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
    perr_set_d  = 1'b0;
`endif
    if (soft_rst_s) begin
      state_d  = RX_IDLE;
      bitcnt_d = 4'd0;
      shift_d  = 8'h00;
      to_d     = '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          to_d = '0;
          if (kclk_fall_s && !kdata_s) begin
            state_d  = RX_RECV;
            bitcnt_d = 4'd0;
          end else begin
            bitcnt_d = 4'd0;
          end
        end
        RX_RECV: begin
          if (kclk_fall_s) begin
            to_d = '0;
            if (bitcnt_q < 4'd8) begin
              shift_d  = {kdata_s, shift_q[7:1]};
              bitcnt_d = bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd8) begin
`ifdef PS2_PARITY_CHECK_EN
              par_d    = kdata_s;
`endif
              bitcnt_d = bitcnt_q + 4'd1;
            end else begin
              state_d     = RX_IDLE;
              bitcnt_d    = 4'd0;
              push_data_d = shift_q;
`ifdef PS2_PARITY_CHECK_EN
              if ((^{shift_q, par_q}) && kdata_s) begin
                push_d = 1'b1;
              end else begin
                perr_set_d = 1'b1;
              end
`else
              push_d = 1'b1;
`endif
            end
          end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stalled partial frame is discarded silently.
            state_d  = RX_IDLE;
            bitcnt_d = 4'd0;
            to_d     = '0;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
        default: begin
          state_d  = RX_IDLE;
          bitcnt_d = 4'd0;
        end
      endcase
    end
  end

  // Storage array needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
      ovf_q <= 1'b0; ie_q <= 1'b1; pending_q <= 1'b0;
    end else if (soft_rst_s) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
      ovf_q <= 1'b0; ie_q <= 1'b1; pending_q <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (ovf_set_s) ovf_q <= 1'b1;
      else if (status_wr_s && write_data_i[1]) ovf_q <= 1'b0;
      // A push in the same cycle as any clear keeps the interrupt pending.
      if (do_push_s) pending_q <= 1'b1;
      else if (interrupt_return_i || (do_pop_s && cnt_q == CW'(1))) pending_q <= 1'b0;
      if (ctrl_wr_s) ie_q <= write_data_i[0];
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perr_q <= 1'b0;
    else if (soft_rst_s) perr_q <= 1'b0;
    else if (perr_set_q) perr_q <= 1'b1;
    else if (status_wr_s && write_data_i[2]) perr_q <= 1'b0;
  end
  assign perr_bit_s = perr_q;
`else
  assign perr_bit_s = 1'b0;
`endif

  always_comb begin
    rdata_s = 32'h0000_0000;
    case (addr_i)
      ADDR_SCAN:   if (!empty_s) rdata_s = {24'h00_0000, mem_q[rd_ptr_q]};
                   else rdata_s = 32'h0000_0000;
      ADDR_STATUS: rdata_s = {16'h0000, cnt8_s, 5'b00000, perr_bit_s, ovf_q, ~empty_s};
      ADDR_CTRL:   rdata_s = {31'h0000_0000, ie_q};
      default:     rdata_s = 32'h0000_0000;
    endcase
  end

  // Read data survives soft reset; only the hardware reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) read_data_q <= 32'h0000_0000;
    else if (rd_s) read_data_q <= rdata_s;
  end

  assign read_data_o         = read_data_q;
  assign interrupt_request_o = pending_q & ie_q & ~empty_s;

endmodule

// File: tb/tb_ps2_fifo_sb_ctrl.sv
// Directed self-checking bench for ps2_fifo_sb_ctrl (short timeout for fast simulation).
module tb_ps2_fifo_sb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        req = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        irq;
  logic        irq_ret = 1'b0;
  logic        kclk = 1'b1;
  logic        kdata = 1'b1;
  int          total = 0;
  int          bad = 0;
  logic [31:0] rd;

  ps2_fifo_sb_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .req_i(req),
    .write_data_i(wdata), .write_enable_i(we), .read_data_o(rdata),
    .interrupt_request_o(irq), .interrupt_return_i(irq_ret),
    .kclk_i(kclk), .kdata_i(kdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1; d = rdata; req = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1; req = 1'b0; we = 1'b0;
  endtask

  task automatic kbit(input logic b);
    kdata = b;
    repeat (3) @(posedge clk);
    kclk = 1'b0;
    repeat (6) @(posedge clk);
    kclk = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par);
    kbit(1'b0);
    for (int i = 0; i < 8; i++) kbit(d[i]);
    kbit((~^d) ^ flip_par);
    kbit(1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_partial(input int nbits);
    kbit(1'b0);
    for (int i = 0; i < nbits; i++) kbit(1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    bus_read(32'h04, rd); check("rst_status", rd, 32'h0);
    bus_read(32'h08, rd); check("rst_ctrl", rd, 32'h1);

    // 1: single frame
    send_frame(8'h1C, 1'b0);
    check("t1_irq", {31'h0, irq}, 32'h1);
    bus_read(32'h04, rd); check("t1_status", rd, 32'h0000_0101);
    bus_read(32'h00, rd); check("t1_scan", rd, 32'h0000_001C);
    bus_read(32'h04, rd); check("t1_status2", rd, 32'h0);
    check("t1_irq2", {31'h0, irq}, 32'h0);
    bus_read(32'h00, rd); check("t1_empty_pop", rd, 32'h0);

    // 2: overflow
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    bus_read(32'h04, rd); check("t2_status", rd, 32'h0000_0803);
    check("t2_irq", {31'h0, irq}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      bus_read(32'h00, rd); check("t2_pop", rd, 32'(i));
    end
    bus_read(32'h04, rd); check("t2_status_ovf", rd, 32'h0000_0002);
    check("t2_irq_empty", {31'h0, irq}, 32'h0);
    bus_write(32'h04, 32'h2);
    bus_read(32'h04, rd); check("t2_ovf_clr", rd, 32'h0);

    // 3: interrupt enable and return
    bus_write(32'h08, 32'h0);
    bus_read(32'h08, rd); check("t3_ctrl0", rd, 32'h0);
    send_frame(8'h5A, 1'b0);
    check("t3_irq_masked", {31'h0, irq}, 32'h0);
    bus_read(32'h04, rd); check("t3_status", rd, 32'h0000_0101);
    bus_write(32'h08, 32'h1);
    check("t3_irq_en", {31'h0, irq}, 32'h1);
    @(negedge clk); irq_ret = 1'b1;
    @(posedge clk); #1; irq_ret = 1'b0;
    check("t3_irq_ret", {31'h0, irq}, 32'h0);
    bus_read(32'h04, rd); check("t3_status2", rd, 32'h0000_0101);
    bus_read(32'h00, rd); check("t3_scan", rd, 32'h0000_005A);

    // 4: bad parity
    send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    bus_read(32'h04, rd); check("t4_perr", rd, 32'h0000_0004);
    bus_write(32'h04, 32'h4);
    bus_read(32'h04, rd); check("t4_perr_clr", rd, 32'h0);
`else
    bus_read(32'h04, rd); check("t4_status", rd, 32'h0000_0101);
    bus_read(32'h00, rd); check("t4_scan", rd, 32'h0000_001C);
`endif

    // 5: timeout then clean frame
    send_partial(4);
    repeat (80) @(posedge clk);
    send_frame(8'h33, 1'b0);
    bus_read(32'h04, rd); check("t5_status", rd, 32'h0000_0101);
    bus_read(32'h00, rd); check("t5_scan", rd, 32'h0000_0033);
    bus_read(32'h04, rd); check("t5_status2", rd, 32'h0);

    // 6: soft reset and hard reset mid-frame
    send_frame(8'h11, 1'b0);
    bus_write(32'h08, 32'h0);
    bus_write(32'h24, 32'h2);
    bus_read(32'h04, rd); check("t6_ignored_rst", rd, 32'h0000_0101);
    send_partial(3);
    bus_write(32'h24, 32'h1);
    check("t6_rdata_hold", rdata, 32'h0000_0101);
    bus_read(32'h04, rd); check("t6_soft_status", rd, 32'h0);
    bus_read(32'h08, rd); check("t6_soft_ctrl", rd, 32'h1);
    send_partial(3);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    check("t6_hard_rdata", rdata, 32'h0);
    check("t6_hard_irq", {31'h0, irq}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    bus_read(32'h08, rd); check("t6_hard_ctrl", rd, 32'h1);
    send_frame(8'h29, 1'b0);
    check("t6_irq", {31'h0, irq}, 32'h1);
    bus_read(32'h04, rd); check("t6_status", rd, 32'h0000_0101);
    bus_read(32'h00, rd); check("t6_scan", rd, 32'h0000_0029);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
